// File: rtl/video_symbol_rx.sv
// BT.656 luma-symbol receiver: timing-code parser, luma averager, bin slicer and BEGIN/END framer.
// Define VIDEO_SYM_GRAY_EN to Gray-code the emitted data symbols.
module video_symbol_rx #(
    parameter int DATA_W     = 4,
    parameter int OSR_LOG2   = 2,
    parameter int LUMA_BASE  = 65,
    parameter int LUMA_STEP  = 10,
    parameter int NUM_LEVELS = 12
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [7:0]        td_in,
    output logic [DATA_W-1:0] sym_out,
    output logic              sym_valid,
    output logic              frame_active,
    output logic              sym_err,
    output logic              line_start
);
    localparam int ACC_W = 8 + OSR_LOG2;
    localparam int CNT_W = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << OSR_LOG2) - 1);
    localparam logic [7:0]       BASE8     = 8'(LUMA_BASE);
    localparam logic [7:0]       STEP8     = 8'(LUMA_STEP);
    localparam logic [7:0]       IDX_BEGIN = 8'(NUM_LEVELS);
    localparam logic [7:0]       IDX_END   = 8'(NUM_LEVELS + 1);

    typedef enum logic [1:0] {P_HUNT, P_FF, P_Z1, P_Z2} pstate_t;
    typedef enum logic {F_WAIT, F_FRAME} fstate_t;

    pstate_t          pstate_q, pstate_d;
    logic             active_q, active_d;
    logic             phase_q, phase_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grp_vld_q, grp_vld_d;
    logic [ACC_W-1:0] grp_sum_q, grp_sum_d;
    logic             perr0_q, perr0_d;
    logic             perr1_q;
    logic             line_start_q, line_start_d;
    logic             s1_vld_q, s1_err_q, s1_err_d;
    logic [7:0]       s1_idx_q, s1_idx_d;
    logic [7:0]       avg, diff;
    logic [DATA_W-1:0] sym_code;

    fstate_t           fstate_q;
    logic [DATA_W-1:0] sym_out_q;
    logic              sym_valid_q, sym_err_q, frame_active_q;

    // Parser and accumulator; timing-code words (including an aborting word) are never sampled.
    always_comb begin
        pstate_d     = pstate_q;
        active_d     = active_q;
        phase_d      = phase_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        grp_vld_d    = 1'b0;
        grp_sum_d    = grp_sum_q;
        perr0_d      = 1'b0;
        line_start_d = 1'b0;
        case (pstate_q)
            P_HUNT: begin
                if (td_in == 8'hFF) begin
                    pstate_d = P_FF;
                end else if (active_q) begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (cnt_q == CNT_LAST) begin
                            grp_vld_d = 1'b1;
                            grp_sum_d = acc_q + ACC_W'(td_in);
                            acc_d     = '0;
                            cnt_d     = '0;
                        end else begin
                            acc_d = acc_q + ACC_W'(td_in);
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            P_FF, P_Z1: begin
                if (td_in == 8'h00) begin
                    pstate_d = (pstate_q == P_FF) ? P_Z1 : P_Z2;
                end else begin
                    pstate_d = P_HUNT;
                    perr0_d  = 1'b1;
                end
            end
            default: begin
                pstate_d = P_HUNT;
                acc_d    = '0;
                cnt_d    = '0;
                phase_d  = 1'b0;
                if (!td_in[4] && !td_in[5]) begin
                    active_d     = 1'b1;
                    line_start_d = 1'b1;
                end else begin
                    active_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        avg      = grp_sum_q[ACC_W-1:OSR_LOG2];
        diff     = avg - BASE8;
        s1_idx_d = diff / STEP8;
        s1_err_d = (avg < BASE8) || (s1_idx_d > IDX_END);
    end

`ifdef VIDEO_SYM_GRAY_EN
    assign sym_code = s1_idx_q[DATA_W-1:0] ^ (s1_idx_q[DATA_W-1:0] >> 1);
`else
    assign sym_code = s1_idx_q[DATA_W-1:0];
`endif

    always_ff @(posedge clkin) begin
        if (rst) begin
            pstate_q     <= P_HUNT;
            active_q     <= 1'b0;
            phase_q      <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            grp_vld_q    <= 1'b0;
            grp_sum_q    <= '0;
            perr0_q      <= 1'b0;
            perr1_q      <= 1'b0;
            line_start_q <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_idx_q     <= '0;
        end else begin
            pstate_q     <= pstate_d;
            active_q     <= active_d;
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            grp_vld_q    <= grp_vld_d;
            grp_sum_q    <= grp_sum_d;
            perr0_q      <= perr0_d;
            perr1_q      <= perr0_q;
            line_start_q <= line_start_d;
            s1_vld_q     <= grp_vld_q;
            s1_err_q     <= s1_err_d;
            s1_idx_q     <= s1_idx_d;
        end
    end

    // Framer: parser aborts are delayed to the same latency as slicer results, so strobes never collide.
    always_ff @(posedge clkin) begin
        if (rst) begin
            fstate_q       <= F_WAIT;
            sym_out_q      <= '0;
            sym_valid_q    <= 1'b0;
            sym_err_q      <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            sym_err_q   <= perr1_q;
            if (s1_vld_q) begin
                if (s1_err_q) begin
                    sym_err_q <= 1'b1;
                end else begin
                    case (fstate_q)
                        F_WAIT: begin
                            if (s1_idx_q == IDX_BEGIN) begin
                                fstate_q       <= F_FRAME;
                                frame_active_q <= 1'b1;
                            end
                        end
                        F_FRAME: begin
                            if (s1_idx_q == IDX_END) begin
                                fstate_q       <= F_WAIT;
                                frame_active_q <= 1'b0;
                            end else if (s1_idx_q < IDX_BEGIN) begin
                                sym_out_q   <= sym_code;
                                sym_valid_q <= 1'b1;
                            end
                        end
                        default: fstate_q <= F_WAIT;
                    endcase
                end
            end
        end
    end

    assign sym_out      = sym_out_q;
    assign sym_valid    = sym_valid_q;
    assign sym_err      = sym_err_q;
    assign frame_active = frame_active_q;
    assign line_start   = line_start_q;
endmodule

// File: tb/tb_video_symbol_rx.sv
// Randomised scoreboard bench for video_symbol_rx against a pixel/group-level reference model.
module tb_video_symbol_rx;
    localparam int DATA_W = 4, OSR_LOG2 = 2, LUMA_BASE = 65, LUMA_STEP = 10, NUM_LEVELS = 12;
    localparam int NSAMP = 1 << OSR_LOG2;

    localparam int K_VALID = 0, K_ERR = 1, K_RISE = 2, K_FALL = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        td_in;
    logic [DATA_W-1:0] sym_out;
    logic              sym_valid, frame_active, sym_err, line_start;

    ev_t exp_q[$];
    int  ls_q[$];
    int  grp[$];
    int  checks = 0, passes = 0;
    int  drv_cyc = 0, mon_cyc = 0;
    int  in_frame = 0, active = 0;

    video_symbol_rx #(
        .DATA_W(DATA_W), .OSR_LOG2(OSR_LOG2), .LUMA_BASE(LUMA_BASE),
        .LUMA_STEP(LUMA_STEP), .NUM_LEVELS(NUM_LEVELS)
    ) dut (
        .clkin(clk), .rst(rst), .td_in(td_in), .sym_out(sym_out), .sym_valid(sym_valid),
        .frame_active(frame_active), .sym_err(sym_err), .line_start(line_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, mon_cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drv_cyc++;
    endtask

    task automatic send(input logic [7:0] w);
        td_in = w;
        tick();
    endtask

    // Reference: average the group, find its bin, then apply the framing rules.
    task automatic eval_group(input int sum, input int cyc);
        int avg, idx;
        ev_t e;
        avg   = sum / NSAMP;
        e.cyc = cyc;
        e.val = 0;
        if (avg < LUMA_BASE || (avg - LUMA_BASE) / LUMA_STEP > NUM_LEVELS + 1) begin
            e.kind = K_ERR;
            exp_q.push_back(e);
            return;
        end
        idx = (avg - LUMA_BASE) / LUMA_STEP;
        if (idx == NUM_LEVELS) begin
            if (in_frame == 0) begin
                e.kind = K_RISE;
                exp_q.push_back(e);
                in_frame = 1;
            end
        end else if (idx == NUM_LEVELS + 1) begin
            if (in_frame == 1) begin
                e.kind = K_FALL;
                exp_q.push_back(e);
                in_frame = 0;
            end
        end else if (in_frame == 1) begin
            e.kind = K_VALID;
`ifdef VIDEO_SYM_GRAY_EN
            e.val = (idx ^ (idx >> 1)) % (1 << DATA_W);
`else
            e.val = idx % (1 << DATA_W);
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic pixel(input int y);
        int sum;
        send(8'($urandom_range(16, 240)));
        send(8'(y));
        if (active == 1) begin
            grp.push_back(y);
            if (grp.size() == NSAMP) begin
                sum = 0;
                foreach (grp[i]) sum += grp[i];
                eval_group(sum, drv_cyc + 2);
                grp.delete();
            end
        end
    endtask

    task automatic pixels(input int n, input int y);
        for (int i = 0; i < n; i++) pixel(y);
    endtask

    task automatic tcode(input logic [7:0] xy);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(xy);
        grp.delete();
        if (!xy[4] && !xy[5]) begin
            active = 1;
            ls_q.push_back(drv_cyc);
        end else begin
            active = 0;
        end
    endtask

    task automatic abort_code(input logic [7:0] b);
        ev_t e;
        send(8'hFF);
        send(b);
        e.kind = K_ERR;
        e.cyc  = drv_cyc + 2;
        e.val  = 0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'h10);
    endtask

    task automatic do_reset();
        ev_t e;
        rst   = 1'b1;
        td_in = 8'h00;
        tick();
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc >= drv_cyc) exp_q.delete(i);
        for (int i = ls_q.size() - 1; i >= 0; i--)
            if (ls_q[i] >= drv_cyc) ls_q.delete(i);
        if (in_frame == 1) begin
            e.kind = K_FALL;
            e.cyc  = drv_cyc;
            e.val  = 0;
            exp_q.push_back(e);
        end
        in_frame = 0;
        active   = 0;
        grp.delete();
        check("rst_sym_out", int'(sym_out), 0);
        check("rst_sym_valid", int'(sym_valid), 0);
        check("rst_sym_err", int'(sym_err), 0);
        check("rst_frame_active", int'(frame_active), 0);
        check("rst_line_start", int'(line_start), 0);
        rst = 1'b0;
    endtask

    // Monitor: every observable output event is matched against the scoreboard.
    initial begin
        int   kind;
        logic prev_fa;
        ev_t  e;
        prev_fa = 1'b0;
        forever begin
            @(posedge clk);
            mon_cyc++;
            #3;
            if (sym_valid && sym_err) check("valid_err_exclusive", 1, 0);
            if (sym_valid || sym_err || (frame_active != prev_fa)) begin
                if (sym_valid) kind = K_VALID;
                else if (sym_err) kind = K_ERR;
                else if (frame_active) kind = K_RISE;
                else kind = K_FALL;
                if (exp_q.size() == 0) begin
                    check("unexpected_event_kind", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", kind, e.kind);
                    check("event_cycle", mon_cyc, e.cyc);
                    if (kind == K_VALID) check("sym_out", int'(sym_out), e.val);
                end
            end
            if (line_start) begin
                if (ls_q.size() == 0) check("unexpected_line_start", 1, 0);
                else check("line_start_cycle", mon_cyc, ls_q.pop_front());
            end
            prev_fa = frame_active;
        end
    end

    initial begin
        int tgt, sel, npix;
        rst   = 1'b1;
        td_in = 8'h00;
        do_reset();
        do_reset();

        tcode(8'h80);
        pixels(4, 100);
        idle(0);
        pixels(4, 190);
        pixels(4, 100);
        pixels(4, 200);
        pixels(4, 190);
        pixel(74); pixel(76); pixel(75); pixel(75);
        pixels(4, 50);
        pixels(2, 130);
        tcode(8'h9D);
        idle(4);
        check("frame_spans_eav", int'(frame_active), in_frame);
        tcode(8'h80);
        pixels(4, 120);
        pixel(100);
        abort_code(8'h12);
        pixels(3, 100);
        pixels(3, 100);
        pixel(100);
        do_reset();
        tcode(8'h80);
        pixels(4, 100);
        tcode(8'h9D);
        idle(6);
        check("no_frame_after_reset", int'(frame_active), 0);

        for (int ln = 0; ln < 40; ln++) begin
            tcode(($urandom_range(0, 5) == 0) ? 8'hAB : 8'h80);
            npix = $urandom_range(6, 24);
            tgt  = 100;
            for (int p = 0; p < npix; p++) begin
                if (p % NSAMP == 0) begin
                    sel = $urandom_range(0, 17);
                    if (sel < 14) tgt = LUMA_BASE + sel * LUMA_STEP + $urandom_range(0, LUMA_STEP - 1);
                    else if (sel < 16) tgt = $urandom_range(40, LUMA_BASE - 1);
                    else tgt = $urandom_range(205, 250);
                end
                if ($urandom_range(0, 19) == 0) abort_code(8'($urandom_range(1, 254)));
                pixel(tgt > 3 ? tgt - $urandom_range(0, 3) : tgt);
            end
            tcode(($urandom_range(0, 3) == 0) ? 8'hB6 : 8'h9D);
            idle($urandom_range(1, 6));
            check("frame_active_line_end", int'(frame_active), in_frame);
        end

        idle(8);
        check("scoreboard_drained", exp_q.size(), 0);
        check("line_start_drained", ls_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
